// File: rtl/immed_gen_stage.sv
// Decode-stage immediate generator: formats I/S/B/U/J/Z/SHAMT, with a tag sideband, into a 2-entry skid buffer.
// Latency: 1 cycle (input accepted at edge N is presented after edge N); full throughput with out_ready high.
// Backpressure: in_ready is registered and drops only when both entries are occupied; flush empties the buffer.
// Ports: clk/rst_n (async, active-low), flush (sync discard), in_valid/in_ready/instr/imm_sel/in_tag (input side),
//        out_valid/out_ready/imm/out_tag/out_illegal (output side, driven directly from the head-entry registers).
module immed_gen_stage #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 8,
    parameter bit AUTO_SEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam bit RV64 = (XLEN == 64);

    typedef enum logic [2:0] {F_I, F_S, F_B, F_U, F_J, F_Z, F_SH} fmt_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    // ---------------- format decode ----------------
    fmt_t            fmt;
    logic            dec_ill;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_new;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        fmt     = F_I;
        dec_ill = 1'b0;
        if (AUTO_SEL) begin
            case (opcode)
                7'b0010011: fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? F_SH : F_I;
                7'b0000011, 7'b1100111, 7'b0001111: fmt = F_I;
                7'b0011011: begin
                    // Word-sized shifts only exist on a 64-bit datapath.
                    if (RV64) fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? F_SH : F_I;
                    else      dec_ill = 1'b1;
                end
                7'b0100011: fmt = F_S;
                7'b1100011: fmt = F_B;
                7'b0110111, 7'b0010111: fmt = F_U;
                7'b1101111: fmt = F_J;
                7'b1110011: fmt = funct3[2] ? F_Z : F_I;
                default:    dec_ill = 1'b1;
            endcase
        end else begin
            case (imm_sel)
                3'b000:  fmt = F_I;
                3'b001:  fmt = F_S;
                3'b010:  fmt = F_B;
                3'b011:  fmt = F_U;
                3'b100:  fmt = F_J;
                3'b101:  fmt = F_Z;
                3'b110:  fmt = F_SH;
                default: dec_ill = 1'b1;
            endcase
        end
    end

    always_comb begin
        imm_new = '0;
        case (fmt)
            F_I:  imm_new = {{(XLEN-12){instr[31]}}, instr[31:20]};
            F_S:  imm_new = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            F_B:  imm_new = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            F_U:  imm_new = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            F_J:  imm_new = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            F_Z:  imm_new = {{(XLEN-5){1'b0}}, instr[19:15]};
            // Shift amount is 6 bits wide only on a 64-bit datapath.
            F_SH: imm_new = {{(XLEN-6){1'b0}}, (RV64 ? instr[25] : 1'b0), instr[24:20]};
            default: imm_new = '0;
        endcase
    end

    // ---------------- 2-entry buffer ----------------
    state_t          state, state_nxt;
    logic            push, pop;
    logic            ld_head_in, ld_head_slot, ld_slot;

    logic [XLEN-1:0]  head_imm, slot_imm;
    logic [TAG_W-1:0] head_tag, slot_tag;
    logic             head_ill, slot_ill;

    assign out_valid   = (state != EMPTY);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign imm         = head_imm;
    assign out_tag     = head_tag;
    assign out_illegal = head_ill;

    always_comb begin
        state_nxt    = state;
        ld_head_in   = 1'b0;
        ld_head_slot = 1'b0;
        ld_slot      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state_nxt  = ONE;
                    ld_head_in = 1'b1;
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = FULL;
                        ld_slot   = 1'b1;
                    end else if (!push && pop) begin
                        state_nxt = EMPTY;
                    end else if (push && pop) begin
                        ld_head_in = 1'b1;
                    end
                end
                FULL: if (pop) begin
                    state_nxt    = ONE;
                    ld_head_slot = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            // Registered copy of "not full" so in_ready never sees out_ready combinationally.
            in_ready <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_imm <= '0;
            head_tag <= '0;
            head_ill <= 1'b0;
            slot_imm <= '0;
            slot_tag <= '0;
            slot_ill <= 1'b0;
        end else begin
            if (ld_head_in) begin
                head_imm <= imm_new;
                head_tag <= in_tag;
                head_ill <= dec_ill;
            end else if (ld_head_slot) begin
                head_imm <= slot_imm;
                head_tag <= slot_tag;
                head_ill <= slot_ill;
            end
            if (ld_slot) begin
                slot_imm <= imm_new;
                slot_tag <= in_tag;
                slot_ill <= dec_ill;
            end
        end
    end

endmodule

// File: doc/immed_gen_stage.md
# immed_gen_stage

Registered, parametrised immediate generator for the decode stage. Takes a full 32-bit instruction plus an immediate-type select (or decodes the type from the opcode), and produces an XLEN-wide sign- or zero-extended immediate. It adds Z-type (CSR uimm) and SHAMT formats and a tag sideband, behind a valid/ready handshake with a 2-entry skid buffer and a synchronous flush. It sits between fetch/decode and the operand-select mux.

## Interface
- XLEN, 32: output width; legal values 32 or 64.
- TAG_W, 8: sideband tag width; tag is carried unchanged with its immediate.
- AUTO_SEL, 0: 1 = ignore IMM_SEL and derive the type from INSTR[6:0]/funct3.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous discard of all buffered entries.
- IN_VALID  in  1  INSTR/IMM_SEL/IN_TAG valid.
- IN_READY  out  1  stage can accept; registered, equals "buffer not full".
- INSTR  in  32  raw instruction.
- IMM_SEL  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110 SHAMT, 111 reserved.
- IN_TAG  in  TAG_W  sideband.
- OUT_VALID  out  1  IMM/OUT_TAG/OUT_ILLEGAL valid.
- OUT_READY  in  1  consumer accepts.
- IMM  out  XLEN  generated immediate.
- OUT_TAG  out  TAG_W  tag of the current output.
- OUT_ILLEGAL  out  1  select or opcode was reserved or unknown.

## Operation
- Formats, where sext/zext extend to XLEN:
  - I: sext(INSTR[31:20]).
  - S: sext({INSTR[31:25],INSTR[11:7]}).
  - B: sext({INSTR[31],INSTR[7],INSTR[30:25],INSTR[11:8],1'b0}).
  - U: sext({INSTR[31:12],12'b0}).
  - J: sext({INSTR[31],INSTR[19:12],INSTR[20],INSTR[30:21],1'b0}).
  - Z: zext(INSTR[19:15]).
  - SHAMT: zext(INSTR[24:20]) when XLEN=32; zext(INSTR[25:20]) when XLEN=64.
- IMM_SEL=111 produces I-format with ILLEGAL=1.
- AUTO_SEL=1 decode by opcode:
  - 0010011 gives SHAMT if funct3 is 001 or 101, else I.
  - 0000011, 1100111 and 0001111 give I.
  - 0011011 gives SHAMT for funct3 001/101, else I, and only when XLEN=64. When XLEN=32 it is illegal.
  - 0100011 gives S; 1100011 gives B; 0110111 and 0010111 give U; 1101111 gives J.
  - 1110011 gives Z if funct3[2]=1, else I.
  - Any other opcode gives I with ILLEGAL=1.
- The immediate is computed combinationally at the input and stored in the buffer. Each entry holds IMM, TAG and ILLEGAL.
- Buffer: 2-entry FIFO with states EMPTY, ONE, FULL.
  - The head entry drives the outputs directly from registers.
  - Push occurs when IN_VALID && IN_READY.
  - Pop occurs when OUT_VALID && OUT_READY.
  - EMPTY: push moves to ONE.
  - ONE: push without pop moves to FULL; pop without push moves to EMPTY; push with pop stays in ONE, and the new entry becomes the head.
  - FULL: pop moves to ONE; a push cannot occur because IN_READY=0.
- FLUSH has priority over push and pop: the next state is EMPTY and any same-cycle input is dropped. OUT_TAG, IMM and OUT_ILLEGAL may hold stale values while OUT_VALID=0.
- The output holds stable while OUT_VALID && !OUT_READY.

## Timing
- Reset (RST_N=0, asynchronous) sets:
  - state EMPTY;
  - OUT_VALID=0, IMM=0, OUT_TAG=0, OUT_ILLEGAL=0;
  - IN_READY=1.
- Latency: an input accepted at edge N appears with OUT_VALID=1 after edge N. It remains until the first edge with OUT_READY=1.
- Throughput is 1 per cycle with OUT_READY held high. IN_READY is never combinational on OUT_READY.
- IN_READY=0 exactly in FULL. It rises on the edge after a pop from FULL.
- Reset asserted mid-transfer discards all entries immediately. Operation resumes on the first edge after RST_N rises.
- FLUSH and pop in the same cycle: flush wins and the pop is not counted.

## Test plan
- XLEN=32, IMM_SEL=000, INSTR=0xFFF00093 -> one cycle later OUT_VALID=1, IMM=0xFFFFFFFF, ILLEGAL=0.
- XLEN=32, IMM_SEL=010, INSTR=0xFE000EE3 -> IMM=0xFFFFFFFC. XLEN=64, IMM_SEL=011, INSTR=0x800000B7 -> IMM=0xFFFFFFFF80000000.
- AUTO_SEL=1, XLEN=64:
  - INSTR=0x03F09093 (slli x1,x1,63) -> IMM=63.
  - INSTR=0x300AD073 (csrrwi, rs1 field 10101) -> IMM=0x15.
  - INSTR=0x0000007F -> ILLEGAL=1.
- Backpressure:
  - With OUT_READY=0, push tags 1, 2, 3 on consecutive cycles -> IN_READY=0 after 2 entries; tag 3 is not accepted while IN_READY=0.
  - Raise OUT_READY -> tags emerge in the order 1, 2, then tag 3 once it is re-presented. Outputs stay stable while stalled.
- FLUSH asserted in FULL with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, and the input is dropped.
- Drop RST_N asynchronously mid-stream -> outputs are zero before the next edge; after release the first push behaves as from EMPTY.
